// File: rtl/clock_pkg.sv
// Shared definitions for the 12-hour clock family: alarm FSM state encodings
// and the 1 Hz tick convention every timer in the family counts against.
package clock_pkg;

  // Alarm sequencing states; encoding 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RINGING = 2'd1,
    ST_SNOOZE  = 2'd2
  } alarm_state_t;

  // tick_1hz is a single clk-cycle pulse once per second, in the clk domain.
  // Timers advance only on cycles where it is high.
  localparam int TICK_PULSE_CYCLES = 1;

endpackage

// File: rtl/second_countdown.sv
// Loadable seconds countdown advanced by the 1 Hz tick; done flags the last
// second (value==1) so the owner can act on the same tick that expires it.
module second_countdown #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_tick,
  output logic         o_done
);

  logic [W-1:0] r_value;

  // Load wins over tick; decrement stops at zero so the counter never wraps.
  always_ff @(posedge clk) begin
    if (reset)                         r_value <= '0;
    else if (i_load)                   r_value <= i_load_val;
    else if (i_tick && r_value != '0)  r_value <= r_value - W'(1);
  end

  assign o_done = (r_value == W'(1));

endmodule

// File: rtl/alarm_ring_controller.sv
// Alarm sequencer between the alarm-compare datapath and the buzzer/buttons:
// ringing with 1 s beep cadence, limited snoozes, dismiss, and ring timeout.
module alarm_ring_controller
  import clock_pkg::*;
#(
  parameter int SNOOZE_SECONDS = 300,
  parameter int RING_TIMEOUT   = 60,
  parameter int MAX_SNOOZES    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       alarm_enable,
  input  logic       alarm_match,
  input  logic       snooze_btn,
  input  logic       dismiss_btn,
  output logic       buzzer,
  output logic       ringing,
  output logic       snoozing,
  output logic [7:0] snooze_count,
  output logic       alarm_missed
);

  localparam int RT_W = $clog2(RING_TIMEOUT + 1);
  localparam int SN_W = $clog2(SNOOZE_SECONDS + 1);

  alarm_state_t    r_state, w_state_nxt;
  logic            r_match_q;
  logic [RT_W-1:0] r_ring_timer, w_ring_timer_nxt;
  logic            r_beep_phase, w_beep_nxt;
  logic [7:0]      r_snooze_count, w_count_nxt;
  logic            w_missed_nxt;
  logic            w_snz_load;
  logic            w_snz_done;
  logic            w_match_rise;
  logic            r_ringing, r_snoozing, r_buzzer, r_alarm_missed;

  assign w_match_rise = alarm_match & ~r_match_q;

  // Match edge detector; cleared by reset so a match held across release fires.
  always_ff @(posedge clk) begin
    if (reset) r_match_q <= 1'b0;
    else       r_match_q <= alarm_match;
  end

  // Snooze interval timer, only ticked while snoozing.
  second_countdown #(.W(SN_W)) u_snooze_cd (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_snz_load),
    .i_load_val (SN_W'(SNOOZE_SECONDS)),
    .i_tick     (tick_1hz && (r_state == ST_SNOOZE)),
    .o_done     (w_snz_done)
  );

  // Next-state and datapath updates; abort/dismiss outrank snooze, which outranks ticks.
  always_comb begin
    w_state_nxt      = r_state;
    w_ring_timer_nxt = r_ring_timer;
    w_beep_nxt       = r_beep_phase;
    w_count_nxt      = r_snooze_count;
    w_missed_nxt     = 1'b0;
    w_snz_load       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_match_rise && alarm_enable) begin
          w_state_nxt      = ST_RINGING;
          w_ring_timer_nxt = '0;
          w_beep_nxt       = 1'b1;
          w_count_nxt      = '0;
        end
      end
      ST_RINGING: begin
        if (!alarm_enable || dismiss_btn) begin
          w_state_nxt = ST_IDLE;
        end else if (snooze_btn && (r_snooze_count < 8'(MAX_SNOOZES))) begin
          w_state_nxt = ST_SNOOZE;
          w_snz_load  = 1'b1;
          w_count_nxt = r_snooze_count + 8'd1;
        end else if (tick_1hz && (r_ring_timer == RT_W'(RING_TIMEOUT - 1))) begin
          w_state_nxt  = ST_IDLE;
          w_missed_nxt = 1'b1;
        end else if (tick_1hz) begin
          w_ring_timer_nxt = r_ring_timer + RT_W'(1);
          w_beep_nxt       = ~r_beep_phase;
        end
      end
      ST_SNOOZE: begin
        if (!alarm_enable || dismiss_btn) begin
          w_state_nxt = ST_IDLE;
        end else if (tick_1hz && w_snz_done) begin
          w_state_nxt      = ST_RINGING;
          w_ring_timer_nxt = '0;
          w_beep_nxt       = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, timers and Moore output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_ring_timer   <= '0;
      r_beep_phase   <= 1'b0;
      r_snooze_count <= '0;
      r_ringing      <= 1'b0;
      r_snoozing     <= 1'b0;
      r_buzzer       <= 1'b0;
      r_alarm_missed <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_ring_timer   <= w_ring_timer_nxt;
      r_beep_phase   <= w_beep_nxt;
      r_snooze_count <= w_count_nxt;
      r_ringing      <= (w_state_nxt == ST_RINGING);
      r_snoozing     <= (w_state_nxt == ST_SNOOZE);
      r_buzzer       <= (w_state_nxt == ST_RINGING) && w_beep_nxt;
      r_alarm_missed <= w_missed_nxt;
    end
  end

  assign ringing      = r_ringing;
  assign snoozing     = r_snoozing;
  assign buzzer       = r_buzzer;
  assign snooze_count = r_snooze_count;
  assign alarm_missed = r_alarm_missed;

endmodule

// File: tb/tb_alarm_ring_controller.sv
// Directed bench for alarm_ring_controller (SNOOZE=5 s, TIMEOUT=4 s, 2 snoozes).
module tb_alarm_ring_controller;

  logic       clk = 1'b0;
  logic       reset, tick_1hz, alarm_enable, alarm_match, snooze_btn, dismiss_btn;
  logic       buzzer, ringing, snoozing, alarm_missed;
  logic [7:0] snooze_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  alarm_ring_controller #(
    .SNOOZE_SECONDS(5), .RING_TIMEOUT(4), .MAX_SNOOZES(2)
  ) dut (
    .clk(clk), .reset(reset), .tick_1hz(tick_1hz), .alarm_enable(alarm_enable),
    .alarm_match(alarm_match), .snooze_btn(snooze_btn), .dismiss_btn(dismiss_btn),
    .buzzer(buzzer), .ringing(ringing), .snoozing(snoozing),
    .snooze_count(snooze_count), .alarm_missed(alarm_missed)
  );

  // One clock cycle of inputs and the outputs expected after that edge.
  typedef struct packed {
    logic       r, e, m, t, s, d;
    logic       ring, snz, buz;
    logic [7:0] cnt;
    logic       miss;
  } vec_t;

  function automatic vec_t mk(logic r, e, m, t, s, d, ring, snz, buz,
                              logic [7:0] cnt, logic miss);
    vec_t v;
    v.r = r; v.e = e; v.m = m; v.t = t; v.s = s; v.d = d;
    v.ring = ring; v.snz = snz; v.buz = buz; v.cnt = cnt; v.miss = miss;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string name);
    logic [11:0] got, exp;
    reset = v.r; alarm_enable = v.e; alarm_match = v.m;
    tick_1hz = v.t; snooze_btn = v.s; dismiss_btn = v.d;
    @(posedge clk);
    #1;
    got = {ringing, snoozing, buzzer, snooze_count, alarm_missed};
    exp = {v.ring, v.snz, v.buz, v.cnt, v.miss};
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got ring=%b snz=%b buz=%b cnt=%0d miss=%b, want ring=%b snz=%b buz=%b cnt=%0d miss=%b",
               name, got[11], got[10], got[9], got[8:1], got[0],
               exp[11], exp[10], exp[9], exp[8:1], exp[0]);
    end
  endtask

  // Shorthand for a cycle with reset low and enable high.
  task automatic step(input logic m, t, s, d, ring, snz, buz,
                      input logic [7:0] cnt, input logic miss, input string name);
    apply(mk(1'b0, 1'b1, m, t, s, d, ring, snz, buz, cnt, miss), name);
  endtask

  vec_t tbl[22];

  initial begin
    reset = 1'b1; tick_1hz = 1'b0; alarm_enable = 1'b0;
    alarm_match = 1'b0; snooze_btn = 1'b0; dismiss_btn = 1'b0;

    //            r  e  m  t  s  d   ring snz buz cnt miss
    tbl[0]  = mk(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0); // reset state
    tbl[1]  = mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 1, 0, 0, 0,  1, 0, 1, 0, 0); // match rise -> ring
    tbl[3]  = mk(0, 1, 1, 0, 0, 0,  1, 0, 1, 0, 0); // held match, no restart
    tbl[4]  = mk(0, 1, 0, 1, 0, 0,  1, 0, 0, 0, 0); // tick1 buzzer off
    tbl[5]  = mk(0, 1, 0, 0, 0, 0,  1, 0, 0, 0, 0);
    tbl[6]  = mk(0, 1, 0, 1, 0, 0,  1, 0, 1, 0, 0); // tick2 on
    tbl[7]  = mk(0, 1, 0, 1, 0, 0,  1, 0, 0, 0, 0); // tick3 off
    tbl[8]  = mk(0, 1, 0, 1, 0, 0,  0, 0, 0, 0, 1); // tick4 timeout
    tbl[9]  = mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0); // missed lasts one cycle
    tbl[10] = mk(0, 1, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    tbl[11] = mk(0, 1, 1, 0, 0, 0,  1, 0, 1, 0, 0);
    tbl[12] = mk(0, 1, 0, 0, 1, 0,  0, 1, 0, 1, 0); // snooze
    tbl[13] = mk(0, 1, 0, 1, 0, 0,  0, 1, 0, 1, 0); // 5->4
    tbl[14] = mk(0, 1, 1, 1, 0, 0,  0, 1, 0, 1, 0); // 4->3, match rise ignored
    tbl[15] = mk(0, 1, 0, 1, 0, 0,  0, 1, 0, 1, 0); // 3->2
    tbl[16] = mk(0, 1, 0, 1, 0, 0,  0, 1, 0, 1, 0); // 2->1
    tbl[17] = mk(0, 1, 0, 1, 0, 0,  1, 0, 1, 1, 0); // 5th tick re-rings
    tbl[18] = mk(0, 1, 0, 1, 0, 0,  1, 0, 0, 1, 0);
    tbl[19] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0); // enable low aborts, count held
    tbl[20] = mk(0, 0, 1, 0, 0, 0,  0, 0, 0, 1, 0); // disabled: rise ignored
    tbl[21] = mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0);

    @(posedge clk); #1;
    for (int i = 0; i < 22; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Snooze limit: two snoozes allowed, third press ignored.
    step(1, 0, 0, 0, 1, 0, 1, 0, 0, "lim_ring");
    step(0, 0, 1, 0, 0, 1, 0, 1, 0, "lim_snz1");
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 1, 0, 1, 0, "lim_wait1");
    step(0, 1, 0, 0, 1, 0, 1, 1, 0, "lim_ring2");
    step(0, 0, 1, 0, 0, 1, 0, 2, 0, "lim_snz2");
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 1, 0, 2, 0, "lim_wait2");
    step(0, 1, 0, 0, 1, 0, 1, 2, 0, "lim_ring3");
    step(0, 0, 1, 0, 1, 0, 1, 2, 0, "lim_snz3_ignored");

    // Dismiss outranks snooze in the same cycle.
    step(0, 0, 1, 1, 0, 0, 0, 2, 0, "dismiss_snooze");

    // Enable low while snoozing returns to idle without a miss.
    step(1, 0, 0, 0, 1, 0, 1, 0, 0, "en_ring");
    step(0, 0, 1, 0, 0, 1, 0, 1, 0, "en_snz");
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "en_abort");

    // Reset mid-snooze with match held: clears, then rings exactly once.
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, "rst_idle");
    step(1, 0, 0, 0, 1, 0, 1, 0, 0, "rst_ring");
    step(1, 0, 1, 0, 0, 1, 0, 1, 0, "rst_snz");
    apply(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0), "rst_clear");
    step(1, 0, 0, 0, 1, 0, 1, 0, 0, "rst_rering");
    step(1, 0, 0, 1, 0, 0, 0, 0, 0, "rst_dismiss");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, "rst_no_refire");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
